// File: rtl/mem_dma.sv
// mem_dma: block-transfer initiator for the data-memory port.
// Copies `length` words from srcAddr to dstAddr, or fills `length` words at
// dstAddr with a constant. It drives the same address/data/write-enable port
// as the CPU. The memory reads asynchronously and commits writes on negedge clk.
//
// Ports
//   clk, rst    clock (posedge) and synchronous active-high reset
//   start       transfer request; only looked at in IDLE
//   mode        0 = copy, 1 = fill
//   srcAddr     copy source base address
//   dstAddr     destination base address
//   length      number of words; zero completes without touching memory
//   fillValue   fill constant
//   memDataIn   asynchronous memory read data
//   memAddress  memory address
//   memDataOut  memory write data
//   memWriteEn  memory write enable
//   busy        high while reading or writing
//   done        single-cycle completion pulse
module mem_dma #(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [p_ADDR_LEN-1:0] srcAddr,
  input  logic [p_ADDR_LEN-1:0] dstAddr,
  input  logic [p_ADDR_LEN-1:0] length,
  input  logic [p_WORD_LEN-1:0] fillValue,
  input  logic [p_WORD_LEN-1:0] memDataIn,
  output logic [p_ADDR_LEN-1:0] memAddress,
  output logic [p_WORD_LEN-1:0] memDataOut,
  output logic                  memWriteEn,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [p_ADDR_LEN-1:0] l_ONE = 1;

  state_t                  state_reg;
  logic [p_ADDR_LEN-1:0]   src_reg;
  logic [p_ADDR_LEN-1:0]   dst_reg;
  logic [p_ADDR_LEN-1:0]   len_reg;
  logic [p_ADDR_LEN-1:0]   cnt_reg;
  logic                    mode_reg;
  // Holds the word being copied. In fill mode it is loaded with the fill
  // constant at start, and it is never overwritten because READ is skipped.
  logic [p_WORD_LEN-1:0]   buffer_reg;
  logic                    we_reg;
  logic                    busy_reg;
  logic                    done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      src_reg    <= '0;
      dst_reg    <= '0;
      len_reg    <= '0;
      cnt_reg    <= '0;
      mode_reg   <= 1'b0;
      buffer_reg <= '0;
      we_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            src_reg    <= srcAddr;
            dst_reg    <= dstAddr;
            len_reg    <= length;
            mode_reg   <= mode;
            buffer_reg <= fillValue;
            cnt_reg    <= '0;
            if (length == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else if (mode) begin
              state_reg <= ST_WRITE;
              we_reg    <= 1'b1;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= ST_READ;
              busy_reg  <= 1'b1;
            end
          end
        end

        ST_READ: begin
          buffer_reg <= memDataIn;
          state_reg  <= ST_WRITE;
          we_reg     <= 1'b1;
        end

        ST_WRITE: begin
          if (cnt_reg == len_reg - l_ONE) begin
            state_reg <= ST_DONE;
            we_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + l_ONE;
            if (!mode_reg) begin
              state_reg <= ST_READ;
              we_reg    <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
          we_reg    <= 1'b0;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // The address and data are decoded only from registered state. The sum
  // wraps naturally at the address width.
  always_comb begin
    memAddress = '0;
    memDataOut = '0;
    case (state_reg)
      ST_READ:  memAddress = src_reg + cnt_reg;
      ST_WRITE: begin
        memAddress = dst_reg + cnt_reg;
        memDataOut = buffer_reg;
      end
      default: begin
        memAddress = '0;
        memDataOut = '0;
      end
    endcase
  end

  assign memWriteEn = we_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_mem_dma.sv
module tb_mem_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [15:0] srcAddr;
  logic [15:0] dstAddr;
  logic [15:0] length;
  logic [15:0] fillValue;
  logic [15:0] memDataIn;
  logic [15:0] memAddress;
  logic [15:0] memDataOut;
  logic        memWriteEn;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  mem_dma #(.p_WORD_LEN(16), .p_ADDR_LEN(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .srcAddr   (srcAddr),
    .dstAddr   (dstAddr),
    .length    (length),
    .fillValue (fillValue),
    .memDataIn (memDataIn),
    .memAddress(memAddress),
    .memDataOut(memDataOut),
    .memWriteEn(memWriteEn),
    .busy      (busy),
    .done      (done)
  );

  // Memory: asynchronous read, write committed on negedge.
  logic [15:0] mem     [0:65535];
  // Reference memory: updated directly from the transfer rules.
  logic [15:0] ref_mem [0:65535];

  assign memDataIn = mem[memAddress];
  always @(negedge clk) if (memWriteEn === 1'b1) mem[memAddress] = memDataOut;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Activity monitor. It counts cycles after the latch edge.
  bit          mon_en = 0;
  int          mon_k, busy_cnt, we_cnt, done_cnt, done_k;
  logic [15:0] wr_q [$];

  always @(negedge clk) begin
    if (mon_en) begin
      mon_k++;
      if (busy === 1'b1) busy_cnt++;
      if (memWriteEn === 1'b1) begin
        we_cnt++;
        wr_q.push_back(memAddress);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_k = mon_k;
      end
    end
  end

  task automatic mon_start();
    mon_k = 0; busy_cnt = 0; we_cnt = 0; done_cnt = 0; done_k = -1;
    wr_q.delete();
    mon_en = 1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic mem_compare(input string tag);
    int bad = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({tag, ".mem"}, bad, 0);
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, ".busy0"}, busy, 0);
    chk({tag, ".we0"}, memWriteEn, 0);
    chk({tag, ".addr0"}, memAddress, 0);
    chk({tag, ".dout0"}, memDataOut, 0);
  endtask

  task automatic run_xfer(input string tag, input logic m, input logic [15:0] s,
                          input logic [15:0] d, input logic [15:0] l, input logic [15:0] f);
    int limit;
    int exp_busy;
    int bad;
    // Reference: the words are copied in ascending order, so an overlapping
    // copy propagates the words that were written earlier.
    for (int i = 0; i < int'(l); i++) begin
      logic [15:0] sa, da;
      sa = s + 16'(i);
      da = d + 16'(i);
      ref_mem[da] = m ? f : ref_mem[sa];
    end
    @(posedge clk); #1;
    mode = m; srcAddr = s; dstAddr = d; length = l; fillValue = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs after the latch; they must have no effect.
    mode = 1'($urandom); srcAddr = 16'($urandom); dstAddr = 16'($urandom);
    length = 16'($urandom); fillValue = 16'($urandom);
    mon_start();
    limit = 2 * int'(l) + 8;
    while (done_cnt == 0 && limit > 0) begin
      @(posedge clk);
      limit--;
    end
    repeat (3) @(posedge clk);
    #1 mon_en = 0;
    exp_busy = m ? int'(l) : 2 * int'(l);
    chk({tag, ".done_cnt"}, done_cnt, 1);
    chk({tag, ".busy_cyc"}, busy_cnt, exp_busy);
    chk({tag, ".done_cyc"}, done_k, exp_busy + 1);
    chk({tag, ".writes"}, we_cnt, int'(l));
    bad = 0;
    if (wr_q.size() != int'(l)) bad++;
    else for (int i = 0; i < int'(l); i++) if (wr_q[i] !== d + 16'(i)) bad++;
    chk({tag, ".wr_seq"}, bad, 0);
    mem_compare(tag);
    idle_outputs(tag);
    $display("xfer %s mode=%0d src=%h dst=%h len=%0d fill=%h busy=%0d writes=%0d",
             tag, m, s, d, l, f, busy_cnt, we_cnt);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    srcAddr = '0; dstAddr = '0; length = '0; fillValue = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    #1;
    idle_outputs("reset");
    chk("reset.done0", done, 0);
    rst = 1'b0;

    // 1: fill
    run_xfer("fill4", 1'b1, 16'h0, 16'h0010, 16'd4, 16'hBEEF);
    chk("fill4.m13", mem[16'h13], 16'hBEEF);
    chk("fill4.m14", mem[16'h14], ref_mem[16'h14]);

    // 2: copy with the source left intact
    poke(16'h20, 16'd1); poke(16'h21, 16'd2); poke(16'h22, 16'd3);
    run_xfer("copy3", 1'b0, 16'h0020, 16'h0040, 16'd3, 16'h0);
    chk("copy3.m42", mem[16'h42], 16'd3);
    chk("copy3.src", mem[16'h21], 16'd2);

    // 3: zero length in both modes
    run_xfer("len0c", 1'b0, 16'h1234, 16'h5678, 16'd0, 16'h0);
    run_xfer("len0f", 1'b1, 16'h0, 16'h5678, 16'd0, 16'hAAAA);

    // 4: overlapping copy propagates the first word
    poke(16'h0, 16'h000A); poke(16'h1, 16'h000B); poke(16'h2, 16'h000C); poke(16'h3, 16'h000D);
    run_xfer("ovlp", 1'b0, 16'h0000, 16'h0001, 16'd3, 16'h0);
    chk("ovlp.m3", mem[16'h3], 16'h000A);

    // 5: address wrap
    run_xfer("wrap", 1'b1, 16'h0, 16'hFFFF, 16'd2, 16'h1234);
    chk("wrap.m0", mem[16'h0], 16'h1234);

    // 6: start re-pulsed while busy, reset after the second WRITE
    for (int i = 0; i < 2; i++) ref_mem[16'h0200 + 16'(i)] = ref_mem[16'h0100 + 16'(i)];
    @(posedge clk); #1;
    mode = 1'b0; srcAddr = 16'h0100; dstAddr = 16'h0200; length = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mon_start();
    @(posedge clk); #1;                       // first WRITE cycle
    mode = 1'b1; dstAddr = 16'h0300; length = 16'd5; fillValue = 16'hDEAD; start = 1'b1;
    @(posedge clk); #1;                       // second READ cycle
    start = 1'b0;
    @(posedge clk); #1;                       // second WRITE cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_outputs("abort");
    repeat (4) @(posedge clk);
    #1 mon_en = 0;
    chk("abort.done_cnt", done_cnt, 0);
    chk("abort.writes", we_cnt, 2);
    mem_compare("abort");
    $display("xfer abort copy len=8 reset after 2 writes, writes=%0d done=%0d", we_cnt, done_cnt);
    run_xfer("after", 1'b0, 16'h0100, 16'h0400, 16'd8, 16'h0);

    // Random transfers
    for (int t = 0; t < 10; t++) begin
      run_xfer($sformatf("rnd%0d", t), 1'($urandom), 16'($urandom), 16'($urandom),
               16'($urandom_range(0, 12)), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
